// File: rtl/mini_src_ctrl_pkg.sv
// Shared encodings for the Mini SRC hardwired control sequencer:
// sequencer states, instruction classes, opcodes, ALU codes and bus sources.
package mini_src_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_MFHI,
    CLS_MFLO,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_DIV  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b00110;
  localparam logic [4:0] OP_NEG  = 5'b00111;
  localparam logic [4:0] OP_MFHI = 5'b01000;
  localparam logic [4:0] OP_MFLO = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b01010;
  localparam logic [4:0] OP_HALT = 5'b01011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_NOT  = 4'b0110;
  localparam logic [3:0] ALU_NEG  = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b0000;

  // GP registers R0-R15 use codes 00000-01111 ({1'b0, reg}).
  localparam logic [4:0] BUS_HI    = 5'b10000;
  localparam logic [4:0] BUS_LO    = 5'b10001;
  localparam logic [4:0] BUS_ZHIGH = 5'b10010;
  localparam logic [4:0] BUS_ZLOW  = 5'b10011;
  localparam logic [4:0] BUS_PC    = 5'b10100;
  localparam logic [4:0] BUS_MDR   = 5'b10101;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decode: splits IR into register fields and
// classifies the opcode into the execute-sequence family it needs.
module instr_decode
  import mini_src_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_e cls,
  output logic [3:0]   alu_op,
  output logic [3:0]   ra,
  output logic [3:0]   rb,
  output logic [3:0]   rc,
  output logic         illegal
);

  logic [4:0] op;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  always_comb begin
    cls     = CLS_ILLEGAL;
    alu_op  = ALU_NONE;
    illegal = 1'b0;
    case (op)
      OP_ADD:  begin cls = CLS_ALU3;   alu_op = ALU_ADD; end
      OP_SUB:  begin cls = CLS_ALU3;   alu_op = ALU_SUB; end
      OP_AND:  begin cls = CLS_ALU3;   alu_op = ALU_AND; end
      OP_OR:   begin cls = CLS_ALU3;   alu_op = ALU_OR;  end
      OP_DIV:  begin cls = CLS_MULDIV; alu_op = ALU_DIV; end
      OP_MUL:  begin cls = CLS_MULDIV; alu_op = ALU_MUL; end
      OP_NOT:  begin cls = CLS_UNARY;  alu_op = ALU_NOT; end
      OP_NEG:  begin cls = CLS_UNARY;  alu_op = ALU_NEG; end
      OP_MFHI: cls = CLS_MFHI;
      OP_MFLO: cls = CLS_MFLO;
      OP_NOP:  cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
      default: begin cls = CLS_ILLEGAL; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: fetch T0-T2, class-specific execute
// T3-T6, Moore outputs decoded from the state register (and IR in T3-T6).
module control_unit
  import mini_src_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic [4:0]  BusDataSelect,
  output logic [3:0]  GP_addr,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_GP,
  output logic        incPC,
  output logic        MDR_read,
  output logic [3:0]  ALU_op,
  output logic        run,
  output logic        illegal_op,
  output logic [3:0]  state_out
);

  state_e       state, next_state;
  instr_class_e cls;
  logic [3:0]   dec_alu, ra, rb, rc;
  logic         dec_illegal;
  logic         unused_ir;

  // IR[14:0] carries immediates the sequencer never looks at.
  assign unused_ir = ^IR[14:0];

  instr_decode u_decode (
    .ir      (IR),
    .cls     (cls),
    .alu_op  (dec_alu),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clock) begin
    if (clear) state <= ST_RST;
    else       state <= next_state;
  end

  assign state_out = state;

  // A class that does not own the current execute step means IR changed
  // mid-instruction; fall back to RST rather than guess.
  always_comb begin
    next_state = ST_RST;
    case (state)
      ST_RST: next_state = ST_T0;
      ST_T0:  next_state = ST_T1;
      ST_T1:  next_state = ST_T2;
      ST_T2:  next_state = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_ALU3, CLS_MULDIV, CLS_UNARY: next_state = ST_T4;
          CLS_HALT:                        next_state = ST_HALTED;
          default:                         next_state = ST_T0;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_ALU3, CLS_MULDIV: next_state = ST_T5;
          CLS_UNARY:            next_state = ST_T0;
          default:              next_state = ST_RST;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_ALU3:   next_state = ST_T0;
          CLS_MULDIV: next_state = ST_T6;
          default:    next_state = ST_RST;
        endcase
      end
      ST_T6:     next_state = (cls == CLS_MULDIV) ? ST_T0 : ST_RST;
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_RST;
    endcase
  end

  always_comb begin
    BusDataSelect = 5'b00000;
    GP_addr       = 4'h0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    ALU_op        = ALU_NONE;
    run           = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      ST_T0: begin
        run = 1'b1; BusDataSelect = BUS_PC; e_MAR = 1'b1; incPC = 1'b1; e_Z = 1'b1;
      end
      ST_T1: begin
        run = 1'b1; BusDataSelect = BUS_ZLOW; e_PC = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1;
      end
      ST_T2: begin
        run = 1'b1; BusDataSelect = BUS_MDR; e_IR = 1'b1;
      end
      ST_T3: begin
        run        = 1'b1;
        illegal_op = dec_illegal;
        case (cls)
          CLS_ALU3:   begin BusDataSelect = {1'b0, rb}; e_Y = 1'b1; end
          CLS_MULDIV: begin BusDataSelect = {1'b0, ra}; e_Y = 1'b1; end
          CLS_UNARY:  begin BusDataSelect = {1'b0, rb}; ALU_op = dec_alu; e_Z = 1'b1; end
          CLS_MFHI:   begin BusDataSelect = BUS_HI; GP_addr = ra; e_GP = 1'b1; end
          CLS_MFLO:   begin BusDataSelect = BUS_LO; GP_addr = ra; e_GP = 1'b1; end
          default:    ;
        endcase
      end
      ST_T4: begin
        run = 1'b1;
        case (cls)
          CLS_ALU3:   begin BusDataSelect = {1'b0, rc}; ALU_op = dec_alu; e_Z = 1'b1; end
          CLS_MULDIV: begin BusDataSelect = {1'b0, rb}; ALU_op = dec_alu; e_Z = 1'b1; end
          CLS_UNARY:  begin BusDataSelect = BUS_ZLOW; GP_addr = ra; e_GP = 1'b1; end
          default:    ;
        endcase
      end
      ST_T5: begin
        run = 1'b1;
        case (cls)
          CLS_ALU3:   begin BusDataSelect = BUS_ZLOW; GP_addr = ra; e_GP = 1'b1; end
          CLS_MULDIV: begin BusDataSelect = BUS_ZLOW; e_LO = 1'b1; end
          default:    ;
        endcase
      end
      ST_T6: begin
        run = 1'b1;
        if (cls == CLS_MULDIV) begin
          BusDataSelect = BUS_ZHIGH;
          e_HI          = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the driver pushes the hand-computed output
// vector expected after each edge; a negedge monitor pops and compares.
module tb_control_unit;

  localparam int W = 30;

  localparam logic [8:0] EN_PC  = 9'b100000000;
  localparam logic [8:0] EN_IR  = 9'b010000000;
  localparam logic [8:0] EN_Y   = 9'b001000000;
  localparam logic [8:0] EN_Z   = 9'b000100000;
  localparam logic [8:0] EN_HI  = 9'b000010000;
  localparam logic [8:0] EN_LO  = 9'b000001000;
  localparam logic [8:0] EN_MDR = 9'b000000100;
  localparam logic [8:0] EN_MAR = 9'b000000010;
  localparam logic [8:0] EN_GP  = 9'b000000001;
  localparam logic [8:0] EN_NONE = 9'b000000000;

  logic        clock;
  logic        clear;
  logic [31:0] IR;
  logic [4:0]  BusDataSelect;
  logic [3:0]  GP_addr;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        incPC, MDR_read, run, illegal_op;
  logic [3:0]  ALU_op;
  logic [3:0]  state_out;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  control_unit dut (
    .clock         (clock),
    .clear         (clear),
    .IR            (IR),
    .BusDataSelect (BusDataSelect),
    .GP_addr       (GP_addr),
    .e_PC          (e_PC),
    .e_IR          (e_IR),
    .e_Y           (e_Y),
    .e_Z           (e_Z),
    .e_HI          (e_HI),
    .e_LO          (e_LO),
    .e_MDR         (e_MDR),
    .e_MAR         (e_MAR),
    .e_GP          (e_GP),
    .incPC         (incPC),
    .MDR_read      (MDR_read),
    .ALU_op        (ALU_op),
    .run           (run),
    .illegal_op    (illegal_op),
    .state_out     (state_out)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {state, bus, gp_addr, enables, incPC, MDR_read, alu_op, run, illegal}
  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic [4:0] bus,
                                      input logic [3:0] gp, input logic [8:0] en,
                                      input logic inc, input logic mdr,
                                      input logic [3:0] alu, input logic rn,
                                      input logic ill);
    return {st, bus, gp, en, inc, mdr, alu, rn, ill};
  endfunction

  logic [W-1:0] obs;
  assign obs = {state_out, BusDataSelect, GP_addr,
                e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
                incPC, MDR_read, ALU_op, run, illegal_op};

  // scoreboard monitor
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (state %0d vs %0d)",
                 n, obs, e, state_out, e[W-1 -: 4]);
      end
    end
  end

  // driver tasks
  task automatic cyc(input logic [W-1:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir, input string n);
    cyc(mk(4'd1, 5'b10100, 4'd0, EN_MAR | EN_Z, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0), {n, "_t0"});
    cyc(mk(4'd2, 5'b10011, 4'd0, EN_PC | EN_MDR, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0), {n, "_t1"});
    IR = ir;
    cyc(mk(4'd3, 5'b10101, 4'd0, EN_IR, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), {n, "_t2"});
  endtask

  logic [W-1:0] rst_v;

  initial begin
    rst_v = mk(4'd0, 5'd0, 4'd0, EN_NONE, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    clear = 1'b1;
    IR    = 32'h0;

    // reset held for two edges
    cyc(rst_v, "rst_a");
    cyc(rst_v, "rst_b");
    clear = 1'b0;

    // MUL Ra=4 Rb=6
    fetch(32'h2A360000, "mul");
    cyc(mk(4'd4, 5'b00100, 4'd0, EN_Y, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "mul_t3");
    cyc(mk(4'd5, 5'b00110, 4'd0, EN_Z, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0), "mul_t4");
    cyc(mk(4'd6, 5'b10011, 4'd0, EN_LO, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "mul_t5");
    cyc(mk(4'd7, 5'b10010, 4'd0, EN_HI, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "mul_t6");

    // ADD R1,R2,R3
    fetch(32'h00918000, "add");
    cyc(mk(4'd4, 5'b00010, 4'd0, EN_Y, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "add_t3");
    cyc(mk(4'd5, 5'b00011, 4'd0, EN_Z, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0), "add_t4");
    cyc(mk(4'd6, 5'b10011, 4'd1, EN_GP, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "add_t5");

    // NOT R7,R9
    fetch(32'h33C80000, "not");
    cyc(mk(4'd4, 5'b01001, 4'd0, EN_Z, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0), "not_t3");
    cyc(mk(4'd5, 5'b10011, 4'd7, EN_GP, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "not_t4");

    // MFHI R5
    fetch(32'h42800000, "mfhi");
    cyc(mk(4'd4, 5'b10000, 4'd5, EN_GP, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "mfhi_t3");

    // MFLO R3
    fetch(32'h49800000, "mflo");
    cyc(mk(4'd4, 5'b10001, 4'd3, EN_GP, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "mflo_t3");

    // NOP
    fetch(32'h50000000, "nop");
    cyc(mk(4'd4, 5'd0, 4'd0, EN_NONE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "nop_t3");

    // illegal opcode 11111: one-cycle pulse, then straight back to fetch
    fetch(32'hF8000000, "ill");
    cyc(mk(4'd4, 5'd0, 4'd0, EN_NONE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1), "ill_t3");

    // HALT, then 20 cycles parked
    fetch(32'h58000000, "halt");
    cyc(mk(4'd4, 5'd0, 4'd0, EN_NONE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "halt_t3");
    for (int i = 0; i < 20; i++)
      cyc(mk(4'd8, 5'd0, 4'd0, EN_NONE, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), "halted");

    // clear is the only exit from HALTED
    clear = 1'b1;
    cyc(rst_v, "halt_clr");
    clear = 1'b0;

    // clear during T4 of MUL aborts the instruction
    fetch(32'h2A360000, "abort");
    cyc(mk(4'd4, 5'b00100, 4'd0, EN_Y, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "abort_t3");
    cyc(mk(4'd5, 5'b00110, 4'd0, EN_Z, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0), "abort_t4");
    clear = 1'b1;
    cyc(rst_v, "abort_rst");
    clear = 1'b0;
    cyc(mk(4'd1, 5'b10100, 4'd0, EN_MAR | EN_Z, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0), "restart_t0");

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
